// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and FSM state types for the APB UART.
package apb_uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_FULL   = 2;
   localparam int ST_RX_EMPTY  = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAME_ERR = 5;

   localparam int CTRL_RX_IRQ  = 0;
   localparam int CTRL_TX_IRQ  = 1;
   localparam int CTRL_LOOP    = 2;
   localparam int CTRL_CLR_OVR = 4;
   localparam int CTRL_CLR_FE  = 5;

   localparam int DIV_MIN = 4;

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

endpackage

// File: rtl/apb_uart_fifo_fifo.sv
// Synchronous FIFO with occupancy count; push when full and pop when
// empty are ignored. Pointers wrap naturally since DEPTH is a power of 2.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr;
   logic             rd;

   assign wr    = push & ~full;
   assign rd    = pop & ~empty;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB UART slave: 8N1 TX/RX with programmable divider, FIFOs, status
// register, interrupt, and wait-state back-pressure on a full TX FIFO.
module apb_uart_fifo
   import apb_uart_pkg::*;
#(
   parameter int                   TX_DEPTH    = 16,
   parameter int                   RX_DEPTH    = 16,
   parameter int                   DIV_WIDTH   = 16,
   parameter logic [DIV_WIDTH-1:0] DIV_RESET   = DIV_WIDTH'(868),
   parameter bit                   BLOCKING_TX = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic [31:0] in_paddr,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic        in_pslverr,
   output logic [31:0] in_prdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   logic [1:0]           addr;
   logic                 access, fire, data_wr, data_rd, ctrl_wr;
   logic [DIV_WIDTH-1:0] div, div_wdata;
   logic [2:0]           ctrl;
   logic                 overrun, frame_err;
   logic [31:0]          status;

   logic                      tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]                tx_dout;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic                      rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]                rx_dout;
   logic [$clog2(RX_DEPTH):0] rx_count;

   assign addr    = in_paddr[3:2];
   assign access  = in_psel & in_penable;
   assign data_wr = access & in_pwrite & (addr == REG_DATA) & in_pstrb[0];
   assign in_pready = access & ~(data_wr & tx_full & BLOCKING_TX);
   assign fire    = in_pready;
   assign tx_push = fire & data_wr & ~tx_full;
   assign data_rd = fire & ~in_pwrite & (addr == REG_DATA);
   assign rx_pop  = data_rd & ~rx_empty;
   assign ctrl_wr = fire & in_pwrite & (addr == REG_CTRL) & in_pstrb[0];
   assign in_pslverr = (data_rd & rx_empty) | (fire & data_wr & tx_full);

   assign div_wdata = (in_pwdata[DIV_WIDTH-1:0] < DIV_WIDTH'(DIV_MIN))
                    ? DIV_WIDTH'(DIV_MIN) : in_pwdata[DIV_WIDTH-1:0];

   always_comb begin
      status = '0;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_RX_EMPTY]  = rx_empty;
      status[ST_OVERRUN]   = overrun;
      status[ST_FRAME_ERR] = frame_err;
      status[15:8]         = 8'(tx_count);
      status[23:16]        = 8'(rx_count);
   end

   always_comb begin
      in_prdata = '0;
      if (access & ~in_pwrite) begin
         unique case (addr)
            REG_DATA:   if (!rx_empty) in_prdata = {24'h0, rx_dout};
            REG_STATUS: in_prdata = status;
            REG_DIV:    in_prdata = 32'(div);
            REG_CTRL:   in_prdata = {29'h0, ctrl};
         endcase
      end
   end

   uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clock(clock), .reset(reset),
      .push(tx_push), .din(in_pwdata[7:0]),
      .pop(tx_pop), .dout(tx_dout),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   // ---------------- transmitter ----------------
   tx_state_t            tx_state, tx_next;
   logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
   logic [2:0]           tx_bit;
   logic [7:0]           tx_shift;
   logic                 tx_end;

   assign tx_end = (tx_cnt == tx_div - 1'b1);

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      unique case (tx_state)
         TX_IDLE: if (!tx_empty) begin
            tx_next = TX_START;
            tx_pop  = 1'b1;
         end
         TX_START: if (tx_end) tx_next = TX_DATA;
         TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP: if (tx_end) begin
            tx_next = tx_empty ? TX_IDLE : TX_START;
            tx_pop  = ~tx_empty;
         end
      endcase
   end

   // The divisor is re-latched at every bit boundary.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DIV_RESET;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_pop) begin
            tx_shift <= tx_dout;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_div   <= div;
         end else if (tx_state != TX_IDLE) begin
            if (tx_end) begin
               tx_cnt <= '0;
               tx_div <= div;
               if (tx_state == TX_DATA) begin
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 1'b1;
               end
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
         end
      end
   end

   assign uart_tx = (tx_state == TX_START) ? 1'b0
                  : (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

   // ---------------- receiver ----------------
   rx_state_t            rx_state, rx_next;
   logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
   logic [2:0]           rx_bit;
   logic [7:0]           rx_shift;
   logic [1:0]           rx_sync;
   logic                 rx_prev, rx_line, rx_half, rx_end;
   logic                 rx_good, rx_fe, rx_ovr;

   assign rx_line = rx_sync[1];
   assign rx_half = (rx_cnt == (rx_div >> 1));
   assign rx_end  = (rx_cnt == rx_div - 1'b1);
   assign rx_push = rx_good & ~rx_full;
   assign rx_ovr  = rx_good & rx_full;

   always_comb begin
      rx_next = rx_state;
      rx_good = 1'b0;
      rx_fe   = 1'b0;
      unique case (rx_state)
         RX_IDLE:  if (rx_prev & ~rx_line) rx_next = RX_START;
         RX_START: if (rx_half) rx_next = rx_line ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: if (rx_end) begin
            rx_next = RX_IDLE;
            rx_good = rx_line;
            rx_fe   = ~rx_line;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_div   <= DIV_RESET;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], ctrl[CTRL_LOOP] ? uart_tx : uart_rx};
         rx_prev  <= rx_line;
         rx_state <= rx_next;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_div <= div;
         end else if ((rx_state == RX_START && rx_half) || rx_end) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
               rx_shift <= {rx_line, rx_shift[7:1]};
               rx_bit   <= rx_bit + 1'b1;
            end
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
      end
   end

   uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clock(clock), .reset(reset),
      .push(rx_push), .din(rx_shift),
      .pop(rx_pop), .dout(rx_dout),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   // ---------------- registers and interrupt ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         div       <= DIV_RESET;
         ctrl      <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (fire & in_pwrite & (addr == REG_DIV)) div <= div_wdata;
         if (ctrl_wr) ctrl <= in_pwdata[2:0];
         if (rx_ovr) overrun <= 1'b1;
         else if (ctrl_wr & in_pwdata[CTRL_CLR_OVR]) overrun <= 1'b0;
         if (rx_fe) frame_err <= 1'b1;
         else if (ctrl_wr & in_pwdata[CTRL_CLR_FE]) frame_err <= 1'b0;
         irq <= (ctrl[CTRL_RX_IRQ] & (~rx_empty | overrun | frame_err))
              | (ctrl[CTRL_TX_IRQ] & tx_empty);
      end
   end

   logic unused;
   assign unused = ^{in_pprot, in_paddr[31:4], in_paddr[1:0],
                     in_pwdata, in_pstrb[3:1]};

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Self-checking bench for apb_uart_fifo: APB register access, TX/RX
// framing, loopback, back-pressure, overrun/frame errors, irq, reset.
module tb_apb_uart_fifo;

   localparam int DIVR = 868;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
   logic [2:0]  in_pprot = 3'd0;
   logic [31:0] in_paddr = '0, in_pwdata = '0;
   logic [3:0]  in_pstrb = 4'h0;
   logic        in_pready, in_pslverr;
   logic [31:0] in_prdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx, irq;

   apb_uart_fifo #(
      .TX_DEPTH(4), .RX_DEPTH(4), .DIV_WIDTH(16),
      .DIV_RESET(16'd868), .BLOCKING_TX(1'b1)
   ) dut (
      .clock(clock), .reset(reset),
      .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
      .in_paddr(in_paddr), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
      .in_pstrb(in_pstrb), .in_pready(in_pready), .in_pslverr(in_pslverr),
      .in_prdata(in_prdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   // Serial line monitor: decodes uart_tx frames at mon_div clocks/bit.
   bit         mon_en = 1'b0;
   int         mon_div = 16;
   int         starts[$];
   logic [7:0] tx_seen[$];
   logic       stop_seen[$];

   always begin : monitor
      int s;
      logic [7:0] b;
      logic stp;
      @(posedge clock); #1;
      if (mon_en && uart_tx === 1'b0) begin
         s = cyc;
         b = '0;
         stp = 1'b0;
         starts.push_back(s);
         for (int k = 1; k <= 9; k++) begin
            while (cyc < s + k * mon_div + mon_div / 2) begin
               @(posedge clock); #1;
            end
            if (k <= 8) b[k-1] = uart_tx;
            else stp = uart_tx;
         end
         tx_seen.push_back(b);
         stop_seen.push_back(stp);
      end
   end

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      logic [7:0] t;
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      t = b >> (idx - 1);
      return t[0];
   endfunction

   task automatic apb(input logic wr, input logic [1:0] ridx,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic err, output int waits);
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr;
      in_paddr = {28'h0, ridx, 2'b00}; in_pwdata = wd; in_pstrb = 4'hf;
      @(posedge clock); #1;
      in_penable = 1'b1;
      #1;
      waits = 0;
      while (!in_pready && waits < 5000) begin
         @(posedge clock); #2;
         waits++;
      end
      if (!in_pready) begin
         n_checks++; n_fail++;
         $display("FAIL apb_timeout: pready=%b required=1", in_pready);
      end
      rd = in_prdata;
      err = in_pslverr;
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] r, input logic [31:0] d,
                         output logic err, output int waits);
      logic [31:0] rd;
      apb(1'b1, r, d, rd, err, waits);
   endtask

   task automatic rd_reg(input logic [1:0] r, output logic [31:0] d,
                         output logic err);
      int w;
      apb(1'b0, r, 32'h0, d, err, w);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stp, input int div);
      logic [9:0] fr;
      fr = {stp, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (div) @(posedge clock);
         #1;
      end
      uart_rx = 1'b1;
      repeat (4 * div) @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic e;
      reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      n_checks++;
      if (uart_tx !== 1'b1 || irq !== 1'b0 || in_pready !== 1'b0 ||
          in_pslverr !== 1'b0 || in_prdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: tx=%b irq=%b rdy=%b err=%b rd=%h required 1 0 0 0 0",
                  uart_tx, irq, in_pready, in_pslverr, in_prdata);
      end
      reset = 1'b0;
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d !== 32'h0000_000a || e !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: got %h err=%b required 0000000a", d, e);
      end
      rd_reg(2'd2, d, e);
      n_checks++;
      if (d !== 32'(DIVR)) begin
         n_fail++;
         $display("FAIL reset_div: got %0d required %0d", d, DIVR);
      end
      rd_reg(2'd3, d, e);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %h required 0", d);
      end
   endtask

   task automatic test_div_clamp;
      logic [31:0] d, vals[4], exp[4];
      logic e;
      int w;
      vals = '{32'd0, 32'd3, 32'd5, 32'd4};
      exp  = '{32'd4, 32'd4, 32'd5, 32'd4};
      for (int i = 0; i < 4; i++) begin
         wr_reg(2'd2, vals[i], e, w);
         rd_reg(2'd2, d, e);
         n_checks++;
         if (d !== exp[i]) begin
            n_fail++;
            $display("FAIL div_clamp: wrote %0d read %0d required %0d", vals[i], d, exp[i]);
         end
      end
   endtask

   task automatic test_tx_frame;
      logic [7:0] bytes[2];
      logic e, expv;
      int w;
      bytes[0] = 8'h55;
      bytes[1] = 8'($urandom);
      for (int n = 0; n < 2; n++) begin
         wr_reg(2'd0, {24'h0, bytes[n]}, e, w);
         n_checks++;
         if (uart_tx !== 1'b1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_pre_start: tx=%b err=%b required 1 0", uart_tx, e);
         end
         for (int k = 0; k < 44; k++) begin
            @(posedge clock); #1;
            expv = (k < 40) ? frame_bit(bytes[n], k / 4) : 1'b1;
            n_checks++;
            if (uart_tx !== expv) begin
               n_fail++;
               $display("FAIL tx_wave: byte %h clk %0d got %b required %b",
                        bytes[n], k, uart_tx, expv);
            end
         end
      end
   endtask

   task automatic test_loopback;
      logic [31:0] d;
      logic e;
      int w, polls;
      logic [7:0] q[$];
      q = '{8'ha3, 8'h0f};
      wr_reg(2'd3, 32'h4, e, w);
      wr_reg(2'd2, 32'd8, e, w);
      foreach (q[i]) wr_reg(2'd0, {24'h0, q[i]}, e, w);
      polls = 0;
      d = '0;
      while (d[23:16] !== 8'd2 && polls < 300) begin
         rd_reg(2'd1, d, e);
         polls++;
      end
      n_checks++;
      if (d[23:16] !== 8'd2) begin
         n_fail++;
         $display("FAIL loop_rx_count: got %0d required 2", d[23:16]);
      end
      foreach (q[i]) begin
         rd_reg(2'd0, d, e);
         n_checks++;
         if (d !== {24'h0, q[i]} || e !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_data: got %h err=%b required %h err=0", d, e, q[i]);
         end
      end
      rd_reg(2'd0, d, e);
      n_checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_empty_read: got %h err=%b required 0 err=1", d, e);
      end
      wr_reg(2'd3, 32'h0, e, w);
      repeat (50) @(posedge clock);
      #1;
   endtask

   task automatic test_blocking;
      logic [7:0] q[$];
      logic e;
      int w, done, t;
      starts.delete(); tx_seen.delete(); stop_seen.delete();
      mon_div = 16;
      wr_reg(2'd2, 32'd16, e, w);
      mon_en = 1'b1;
      done = 0;
      for (int i = 0; i < 6; i++) begin
         q.push_back(8'($urandom));
         wr_reg(2'd0, {24'h0, q[i]}, e, w);
         n_checks++;
         if ((i < 5 && w != 0) || (i == 5 && w == 0) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL block_wait: write %0d waits=%0d err=%b required %s err=0",
                     i, w, e, (i < 5) ? "0" : ">0");
         end
         if (i == 5) done = cyc;
      end
      n_checks++;
      if (starts.size() == 0 || done != starts[0] + 10 * 16 + 1) begin
         n_fail++;
         $display("FAIL block_release_cycle: got %0d required %0d", done,
                  (starts.size() > 0) ? starts[0] + 161 : -1);
      end
      t = 0;
      while (tx_seen.size() < 6 && t < 3000) begin
         @(posedge clock); #1;
         t++;
      end
      mon_en = 1'b0;
      n_checks++;
      if (tx_seen.size() != 6) begin
         n_fail++;
         $display("FAIL block_frame_count: got %0d required 6", tx_seen.size());
      end
      for (int i = 0; i < 6 && i < tx_seen.size(); i++) begin
         n_checks++;
         if (tx_seen[i] !== q[i] || stop_seen[i] !== 1'b1 ||
             (i > 0 && starts[i] - starts[i-1] != 160)) begin
            n_fail++;
            $display("FAIL block_frame: #%0d got %h stop=%b gap=%0d required %h 1 160",
                     i, tx_seen[i], stop_seen[i],
                     (i > 0) ? starts[i] - starts[i-1] : 160, q[i]);
         end
      end
   endtask

   task automatic test_rx_overrun;
      logic [7:0] q[$], g;
      logic [31:0] d;
      logic e;
      int w;
      wr_reg(2'd2, 32'd8, e, w);
      for (int i = 0; i < 5; i++) begin
         g = 8'($urandom);
         if (i < 4) q.push_back(g);
         send_byte(g, 1'b1, 8);
      end
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d[4] !== 1'b1 || d[23:16] !== 8'd4 || d[2] !== 1'b1 || d[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_overrun_status: got %h required ovr=1 full=1 cnt=4 fe=0", d);
      end
      foreach (q[i]) begin
         rd_reg(2'd0, d, e);
         n_checks++;
         if (d !== {24'h0, q[i]} || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_data: #%0d got %h err=%b required %h", i, d, e, q[i]);
         end
      end
      wr_reg(2'd3, 32'h10, e, w);
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d[4] !== 1'b0 || d[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_overrun_clear: got %h required ovr=0 empty=1", d);
      end
      g = 8'($urandom);
      send_byte(g, 1'b1, 8);
      send_byte(8'($urandom), 1'b0, 8);
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d[5] !== 1'b1 || d[23:16] !== 8'd1) begin
         n_fail++;
         $display("FAIL rx_frame_err: got %h required fe=1 cnt=1", d);
      end
      rd_reg(2'd0, d, e);
      n_checks++;
      if (d !== {24'h0, g}) begin
         n_fail++;
         $display("FAIL rx_after_fe: got %h required %h", d, g);
      end
      wr_reg(2'd3, 32'h20, e, w);
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_fe_clear: got %h required fe=0", d);
      end
   endtask

   task automatic test_irq;
      logic [31:0] d;
      logic e;
      int w;
      wr_reg(2'd3, 32'h2, e, w);
      @(posedge clock); #1;
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_tx_empty: got %b required 1", irq);
      end
      wr_reg(2'd3, 32'h1, e, w);
      @(posedge clock); #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_rx_idle: got %b required 0", irq);
      end
      send_byte(8'($urandom), 1'b1, 8);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_rx_data: got %b required 1", irq);
      end
      rd_reg(2'd0, d, e);
      @(posedge clock); #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_rx_drained: got %b required 0", irq);
      end
      wr_reg(2'd3, 32'h0, e, w);
   endtask

   task automatic test_reset_midframe;
      logic [31:0] d;
      logic e;
      int w, base, lows;
      wr_reg(2'd2, 32'd4, e, w);
      wr_reg(2'd0, 32'hff, e, w);
      base = cyc;
      wr_reg(2'd0, 32'h00, e, w);
      while (cyc < base + 18) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      n_checks++;
      if (uart_tx !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_tx: got %b required 1", uart_tx);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      rd_reg(2'd1, d, e);
      n_checks++;
      if (d !== 32'h0000_000a) begin
         n_fail++;
         $display("FAIL midframe_status: got %h required 0000000a", d);
      end
      rd_reg(2'd2, d, e);
      n_checks++;
      if (d !== 32'(DIVR)) begin
         n_fail++;
         $display("FAIL midframe_div: got %0d required %0d", d, DIVR);
      end
      lows = 0;
      repeat (200) begin
         @(posedge clock); #1;
         if (uart_tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL midframe_no_frame: low clocks %0d required 0", lows);
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_div_clamp();
      test_tx_frame();
      test_loopback();
      test_blocking();
      test_rx_overrun();
      test_irq();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
